// File: rtl/ring_johnson_cnt_if.sv
// Control/status bundle for ring_johnson_cnt: the sequencer (master) drives the
// controls, the counter (slave) returns its state and the wrap/illegal pulses.
interface ring_johnson_cnt_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             wrap;
    logic             illegal;

    modport master (
        output en, mode, dir, load, load_val,
        input  out, wrap, illegal
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output out, wrap, illegal
    );
endinterface

// File: rtl/ring_johnson_cnt.sv
// WIDTH-bit one-hot ring / Johnson shift counter with load, wrap pulse and, when
// RINGCNT_SELFCORRECT_EN is defined, illegal-state detection with return to home.
module ring_johnson_cnt #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    ring_johnson_cnt_if.slave bus
);
    localparam logic [WIDTH-1:0] HOME = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] out_q = HOME;
    logic [WIDTH-1:0] out_d;
    logic             wrap_q = 1'b0;
    logic             wrap_d;
    logic             illegal_q = 1'b0;
    logic             illegal_d;
    logic [WIDTH-1:0] shift_val;
    logic             feedback;

    // Johnson differs from ring only by inverting the bit that wraps around.
    always_comb begin
        feedback  = 1'b0;
        shift_val = out_q;
        if (bus.dir == 1'b0) begin
            feedback  = out_q[0] ^ bus.mode;
            shift_val = {feedback, out_q[WIDTH-1:1]};
        end else begin
            feedback  = out_q[WIDTH-1] ^ bus.mode;
            shift_val = {out_q[WIDTH-2:0], feedback};
        end
    end

`ifdef RINGCNT_SELFCORRECT_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] ones_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             state_legal;

    // Ring states must be one-hot; Johnson states may hold at most one 0/1 boundary.
    always_comb begin
        ones_cnt = '0;
        edge_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_cnt = ones_cnt + CNT_W'(out_q[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            edge_cnt = edge_cnt + CNT_W'(out_q[i] ^ out_q[i+1]);
        end
        state_legal = bus.mode ? (edge_cnt <= CNT_W'(1)) : (ones_cnt == CNT_W'(1));
    end
`endif

    always_comb begin
        out_d     = out_q;
        wrap_d    = 1'b0;
        illegal_d = 1'b0;
        if (bus.load) begin
            out_d = bus.load_val;
        end else if (bus.en) begin
`ifdef RINGCNT_SELFCORRECT_EN
            if (!state_legal) begin
                out_d     = HOME;
                illegal_d = 1'b1;
            end else begin
                out_d  = shift_val;
                wrap_d = (shift_val == HOME);
            end
`else
            out_d  = shift_val;
            wrap_d = (shift_val == HOME);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= HOME;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.wrap    = wrap_q;
    assign bus.illegal = illegal_q;
endmodule
